// File: rtl/data_mem_resp.sv
// Data-memory responder: one load/store at a time over valid/ready, with a
// fixed access latency, byte/half/word stores and extended load data.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | latency countdown; access performed when cnt reaches 0
// RESP  | response held until resp_ready
module data_mem_resp #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [7:0]  req_wmask,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_rmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, wdata_q;
    logic        wen_q;
    logic [7:0]  wmask_q;
    logic [2:0]  rmask_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic             range_err, align_err, type_err, err, access;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data, rd_word, load_data;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;

    // Offset into the array; addresses below BASE_ADDR wrap large and fail the range test.
    assign off       = addr_q - BASE_ADDR;
    assign idx       = off[IDX_W+1:2];
    assign range_err = ({1'b0, off} >= MEM_BYTES);
    assign err       = range_err | align_err | type_err;
    assign access    = (state == BUSY) && (cnt == 4'd0);
    assign byte_en   = wmask_q[3:0] << addr_q[1:0];
    assign lane_data = wdata_q << {addr_q[1:0], 3'b000};
    assign rd_word   = mem[idx];

    // Alignment and legality of the captured size/type.
    always_comb begin
        align_err = 1'b0;
        type_err  = 1'b0;
        if (wen_q) begin
            case (wmask_q)
                8'h01:   align_err = 1'b0;
                8'h03:   align_err = addr_q[0];
                8'h0F:   align_err = |addr_q[1:0];
                default: type_err  = 1'b1;
            endcase
        end else begin
            case (rmask_q)
                3'd0:       align_err = |addr_q[1:0];
                3'd1, 3'd2: align_err = addr_q[0];
                3'd3, 3'd4: align_err = 1'b0;
                default:    type_err  = 1'b1;
            endcase
        end
    end

    // Lane select and sign/zero extension of load data.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (rmask_q)
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_data = {16'h0000, rd_half};
            3'd3:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    load_data = {24'h000000, rd_byte};
            default: load_data = rd_word;
        endcase
    end

    // Next-state, latency counter and handshake outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                else             state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request capture at acceptance; inputs are ignored afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rmask_q <= '0;
        end else if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wmask_q <= req_wmask;
            wdata_q <= req_wdata;
            rmask_q <= req_rmask;
        end
    end

    // Response registers, loaded on the access cycle and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_err   <= err;
            resp_rdata <= (err || wen_q) ? 32'h0 : load_data;
        end
    end

    // Array write on the access cycle; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (access && wen_q && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed plan items plus randomized loads/stores
// compared against a byte-addressed reference memory.
module tb_data_mem_resp;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [7:0]  req_wmask;
    logic [2:0]  req_rmask;

    logic        req_valid_1, req_ready_1, req_wen_1, resp_valid_1, resp_ready_1, resp_err_1;
    logic [31:0] req_addr_1, req_wdata_1, resp_rdata_1;
    logic [7:0]  req_wmask_1;
    logic [2:0]  req_rmask_1;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .req_rmask(req_rmask), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_1), .req_ready(req_ready_1), .req_addr(req_addr_1),
        .req_wen(req_wen_1), .req_wmask(req_wmask_1), .req_wdata(req_wdata_1),
        .req_rmask(req_rmask_1), .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
        .resp_rdata(resp_rdata_1), .resp_err(resp_err_1)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference memory: byte offset from BASE -> byte value.
    logic [7:0] ref_mem [int unsigned];

    function automatic void ref_access(input logic [31:0] a, input logic w, input logic [7:0] wm,
                                       input logic [31:0] wd, input logic [2:0] rm,
                                       output logic [31:0] rd, output logic er);
        int unsigned off, size;
        bit          sgn;
        longint      val;
        off  = a - BASE;
        sgn  = 1'b0;
        size = 0;
        if (w) begin
            if (wm == 8'h01) size = 1;
            else if (wm == 8'h03) size = 2;
            else if (wm == 8'h0F) size = 4;
        end else begin
            case (rm)
                3'd0: size = 4;
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 2;
                3'd3: begin size = 1; sgn = 1'b1; end
                3'd4: size = 1;
                default: size = 0;
            endcase
        end
        rd = 32'h0;
        if (size == 0) er = 1'b1;
        else er = (off >= DEPTH * 4) || ((a % size) != 0);
        if (!er) begin
            if (w) begin
                for (int b = 0; b < int'(size); b++) ref_mem[off + b] = 8'(wd >> (8 * b));
            end else begin
                val = 0;
                for (int b = 0; b < int'(size); b++) val += longint'(ref_mem[off + b]) << (8 * b);
                if (sgn && val >= (longint'(1) << (8 * size - 1))) val -= longint'(1) << (8 * size);
                rd = val[31:0];
            end
        end
    endfunction

    task automatic do_req(input logic [31:0] a, input logic w, input logic [7:0] wm,
                          input logic [31:0] wd, input logic [2:0] rm,
                          output logic [31:0] rd, output logic er, output int lat);
        int wait_cyc;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_wen = w;
        req_wmask = wm; req_wdata = wd; req_rmask = rm;
        wait_cyc = 0;
        while (!req_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        #1;
        // Scramble the request bus after acceptance; the captured copy must be used.
        req_valid = 1'b0; req_addr = $urandom; req_wen = 1'($urandom);
        req_wmask = 8'($urandom); req_wdata = $urandom; req_rmask = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 50);
        rd = resp_rdata;
        er = resp_err;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic w, input logic [7:0] wm,
                       input logic [31:0] wd, input logic [2:0] rm, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        exp_er, er;
        int          lat;
        ref_access(a, w, wm, wd, rm, exp_rd, exp_er);
        do_req(a, w, wm, wd, rm, rd, er, lat);
        check({tag, " rdata"}, rd, exp_rd);
        check({tag, " err"}, 32'(er), 32'(exp_er));
        check({tag, " latency"}, 32'(lat), 32'd2);
    endtask

    logic [31:0] rd;
    logic [31:0] held, exp_rd;
    logic        exp_er;
    logic [31:0] a;
    logic [7:0]  wm;
    int          wait_cyc;

    // LATENCY=1 streaming plan: 4 stores then 4 loads.
    logic [31:0] l1_addr [8] = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 4, BASE + 5, BASE + 8, BASE + 8};
    logic        l1_wen  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] l1_data [8] = '{32'h1122_3344, 32'h8899_AABB, 32'hFFFF_8000, 32'h0000_007F, 0, 0, 0, 0};
    logic [2:0]  l1_rm   [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1};
    logic [31:0] l1_exp  [8] = '{0, 0, 0, 0, 32'h8899_AABB, 32'hFFFF_FFAA, 32'h0000_8000, 32'hFFFF_8000};
    int          acc_cyc [8];
    int          rsp_cyc [8];

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = 0; req_addr = 0; req_wen = 0; req_wmask = 0; req_wdata = 0; req_rmask = 0;
        resp_ready = 0;
        req_valid_1 = 0; req_addr_1 = 0; req_wen_1 = 0; req_wmask_1 = 0; req_wdata_1 = 0; req_rmask_1 = 0;
        resp_ready_1 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        check("rst resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Every byte of the first 64 is defined before any load.
        for (int i = 0; i < 16; i++) txn("init sw", BASE + 32'(4 * i), 1'b1, 8'h0F, 32'h0, 3'd0, rd);

        txn("sw deadbeef", BASE + 32'h10, 1'b1, 8'h0F, 32'hDEAD_BEEF, 3'd0, rd);
        txn("lw deadbeef", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        check("lw deadbeef const", rd, 32'hDEAD_BEEF);

        txn("sw zero", BASE + 32'h10, 1'b1, 8'h0F, 32'h0, 3'd0, rd);
        txn("sb 80", BASE + 32'h13, 1'b1, 8'h01, 32'h0000_0080, 3'd0, rd);
        txn("lw after sb", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        check("lw after sb const", rd, 32'h8000_0000);
        txn("lb", BASE + 32'h13, 1'b0, 8'h00, 32'h0, 3'd3, rd);
        check("lb const", rd, 32'hFFFF_FF80);
        txn("lbu", BASE + 32'h13, 1'b0, 8'h00, 32'h0, 3'd4, rd);
        check("lbu const", rd, 32'h0000_0080);
        txn("sh 8001", BASE + 32'h10, 1'b1, 8'h03, 32'h0000_8001, 3'd0, rd);
        txn("lh", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd1, rd);
        check("lh const", rd, 32'hFFFF_8001);
        txn("lhu", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd2, rd);
        check("lhu const", rd, 32'h0000_8001);

        txn("err lw misaligned", BASE + 32'h12, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        txn("err sh misaligned", BASE + 32'h11, 1'b1, 8'h03, 32'hFFFF_FFFF, 3'd0, rd);
        txn("err lw below base", 32'h7FFF_FFFC, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        txn("err lw past end", BASE + 32'(DEPTH * 4), 1'b0, 8'h00, 32'h0, 3'd0, rd);
        txn("err rmask5", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd5, rd);
        txn("err wmask07", BASE + 32'h10, 1'b1, 8'h07, 32'hFFFF_FFFF, 3'd0, rd);
        txn("lw after errors", BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        txn("sw 14", BASE + 32'h14, 1'b1, 8'h0F, 32'h0A0B_0C0D, 3'd0, rd);

        // Backpressure: response held for 10 cycles, a request pulsed meanwhile.
        ref_access(BASE + 32'h10, 1'b0, 8'h00, 32'h0, 3'd0, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h10; req_wen = 1'b0; req_rmask = 3'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_cyc = 0;
        while (!resp_valid && wait_cyc < 50) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        held = resp_rdata;
        check("bp first rdata", held, exp_rd);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = (i == 4); req_addr = BASE + 32'h14; req_wen = 1'b1;
            req_wmask = 8'h0F; req_wdata = 32'h5555_5555;
            @(posedge clk);
            #1;
            check("bp resp_valid", 32'(resp_valid), 32'd1);
            check("bp rdata stable", resp_rdata, held);
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("bp req_ready after hs", 32'(req_ready), 32'd1);
        check("bp resp_valid after hs", 32'(resp_valid), 32'd0);
        txn("lw 14 after bp", BASE + 32'h14, 1'b0, 8'h00, 32'h0, 3'd0, rd);

        // Reset while a store is in BUSY: discarded, outputs cleared.
        txn("lw before rst", BASE + 32'h14, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_addr = BASE + 32'h20; req_wen = 1'b1;
        req_wmask = 8'h0F; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst resp_valid", 32'(resp_valid), 32'd0);
        check("midrst rdata", resp_rdata, 32'd0);
        check("midrst err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn("lw 20 after rst", BASE + 32'h20, 1'b0, 8'h00, 32'h0, 3'd0, rd);
        check("lw 20 after rst const", rd, 32'h0);

        // Randomized traffic inside the defined window, with occasional out-of-range addresses.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE + 32'(DEPTH * 4) + $urandom_range(0, 255);
                1:       a = BASE - 32'd1 - $urandom_range(0, 255);
                default: a = BASE + $urandom_range(0, 63);
            endcase
            case ($urandom_range(0, 3))
                0:       wm = 8'h01;
                1:       wm = 8'h03;
                2:       wm = 8'h0F;
                default: wm = 8'($urandom);
            endcase
            txn("rand", a, 1'($urandom), wm, $urandom, 3'($urandom_range(0, 7)), rd);
        end

        // LATENCY=1 streaming with resp_ready and req_valid held high.
        // Accept-to-accept spacing is one cycle each of IDLE, BUSY and RESP.
        resp_ready_1 = 1'b1;
        @(negedge clk);
        req_valid_1 = 1'b1; req_addr_1 = l1_addr[0]; req_wen_1 = l1_wen[0];
        req_wmask_1 = 8'h0F; req_wdata_1 = l1_data[0]; req_rmask_1 = l1_rm[0];
        begin
            int ireq, irsp;
            logic acc;
            ireq = 0;
            irsp = 0;
            for (int cyc = 0; cyc < 80 && irsp < 8; cyc++) begin
                acc = req_valid_1 && req_ready_1;
                @(posedge clk);
                #1;
                if (acc) begin
                    acc_cyc[ireq] = cyc;
                    ireq++;
                    if (ireq < 8) begin
                        req_addr_1 = l1_addr[ireq]; req_wen_1 = l1_wen[ireq];
                        req_wdata_1 = l1_data[ireq]; req_rmask_1 = l1_rm[ireq];
                    end else begin
                        req_valid_1 = 1'b0;
                    end
                end
                if (resp_valid_1) begin
                    rsp_cyc[irsp] = cyc;
                    check("lat1 rdata", resp_rdata_1, l1_exp[irsp]);
                    check("lat1 err", 32'(resp_err_1), 32'd0);
                    irsp++;
                end
                @(negedge clk);
            end
            req_valid_1 = 1'b0;
            check("lat1 responses", 32'(irsp), 32'd8);
            for (int i = 0; i < irsp && i < ireq; i++) begin
                check("lat1 latency", 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
                if (i > 0) check("lat1 spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
